// File: rtl/iram_port_arbiter_pkg.sv
// Shared encodings for the iRAM port arbiter: FSM states, access owners, default widths.
package iram_port_arbiter_pkg;

    localparam int IRAM_ADDR_W = 8;
    localparam int IRAM_DATA_W = 24;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR     = 3'd1;
    localparam logic [2:0] ST_WR_ACK = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_RD_CAP = 3'd4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DBG  = 2'd3
    } owner_t;

endpackage

// File: rtl/iram_port_arbiter_if.sv
// Requester-side and iRAM-side signals of the iRAM port arbiter.
interface iram_port_arbiter_if
    import iram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = IRAM_ADDR_W,
    parameter int DATA_W = IRAM_DATA_W
);
    logic              cpu_paused;
    logic              ld_write_enable;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              fetch_stall;
    logic              dbg_rd_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_valid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output cpu_paused, ld_write_enable, ld_addr, ld_data,
        output fetch_req, fetch_addr, dbg_rd_req, dbg_addr, ram_rdata,
        input  ld_ack, fetch_data, fetch_valid, fetch_stall,
        input  dbg_data, dbg_valid, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  cpu_paused, ld_write_enable, ld_addr, ld_data,
        input  fetch_req, fetch_addr, dbg_rd_req, dbg_addr, ram_rdata,
        output ld_ack, fetch_data, fetch_valid, fetch_stall,
        output dbg_data, dbg_valid, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/iram_port_arbiter_grant_select.sv
// Eligibility and priority resolve for the three iRAM requesters, plus the debug aging counter.
module iram_grant_select
    import iram_port_arbiter_pkg::*;
#(
    parameter int DBG_MAX_WAIT = 4,
    parameter int WAIT_W       = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   idle,
    input  logic   cpu_paused,
    input  logic   ld_write_enable,
    input  logic   ld_ack,
    input  logic   fetch_req,
    input  logic   fetch_valid,
    input  logic   dbg_rd_req,
    input  logic   dbg_valid,
    output owner_t grant
);

    logic              ld_elig;
    logic              cpu_elig;
    logic              dbg_elig;
    logic              dbg_aged;
    logic [WAIT_W-1:0] age_cnt;

    // A requester still seeing its own ack/valid is mid-deassert and must not be served twice.
    assign ld_elig  = ld_write_enable & ~ld_ack;
    assign cpu_elig = fetch_req & ~fetch_valid & ~cpu_paused;
    assign dbg_elig = dbg_rd_req & ~dbg_valid;
    assign dbg_aged = (age_cnt >= WAIT_W'(DBG_MAX_WAIT));

    always_comb begin
        grant = OWN_NONE;
        if (idle) begin
            if (ld_elig)                    grant = OWN_LD;
            else if (dbg_elig && dbg_aged)  grant = OWN_DBG;
            else if (cpu_elig)              grant = OWN_CPU;
            else if (dbg_elig)              grant = OWN_DBG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_cnt <= '0;
        end else if (!dbg_rd_req) begin
            age_cnt <= '0;
        end else if (idle && dbg_elig) begin
            if (grant == OWN_DBG)
                age_cnt <= '0;
            else if (age_cnt != {WAIT_W{1'b1}})
                age_cnt <= age_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iram_port_arbiter.sv
// Single-port iRAM arbiter: loader writes, CPU fetches and debug reads share one RAM port.
//
// state     | meaning
// IDLE      | no access in flight; arbitrate
// WR        | write strobe on the RAM port
// WR_ACK    | ld_ack pulse, port released
// RD        | read strobe on the RAM port
// RD_CAP    | RAM data arrives; captured into the owner's data register
module iram_port_arbiter
    import iram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = IRAM_ADDR_W,
    parameter int DATA_W       = IRAM_DATA_W,
    parameter int DBG_MAX_WAIT = 4,
    parameter int WAIT_W       = 3
) (
    input logic                clk,
    input logic                rst,
    iram_port_arbiter_if.slave bus
);

    logic [2:0]        state;
    owner_t            grant;
    owner_t            rd_owner;
    logic              ld_ack;
    logic              fetch_valid;
    logic              dbg_valid;
    logic [DATA_W-1:0] fetch_data;
    logic [DATA_W-1:0] dbg_data;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    iram_grant_select #(
        .DBG_MAX_WAIT (DBG_MAX_WAIT),
        .WAIT_W       (WAIT_W)
    ) u_grant (
        .clk             (clk),
        .rst             (rst),
        .idle            (state == ST_IDLE),
        .cpu_paused      (bus.cpu_paused),
        .ld_write_enable (bus.ld_write_enable),
        .ld_ack          (ld_ack),
        .fetch_req       (bus.fetch_req),
        .fetch_valid     (fetch_valid),
        .dbg_rd_req      (bus.dbg_rd_req),
        .dbg_valid       (dbg_valid),
        .grant           (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_owner    <= OWN_NONE;
            ld_ack      <= 1'b0;
            fetch_valid <= 1'b0;
            dbg_valid   <= 1'b0;
            fetch_data  <= '0;
            dbg_data    <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ld_ack      <= 1'b0;
            fetch_valid <= 1'b0;
            dbg_valid   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (grant)
                        OWN_LD: begin
                            state     <= ST_WR;
                            ram_en    <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_addr  <= bus.ld_addr;
                            ram_wdata <= bus.ld_data;
                        end
                        OWN_CPU: begin
                            state    <= ST_RD;
                            ram_en   <= 1'b1;
                            ram_addr <= bus.fetch_addr;
                            rd_owner <= OWN_CPU;
                        end
                        OWN_DBG: begin
                            state    <= ST_RD;
                            ram_en   <= 1'b1;
                            ram_addr <= bus.dbg_addr;
                            rd_owner <= OWN_DBG;
                        end
                        default: ;
                    endcase
                end
                ST_WR: begin
                    state  <= ST_WR_ACK;
                    ld_ack <= 1'b1;
                end
                ST_WR_ACK: state <= ST_IDLE;
                ST_RD:     state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    state <= ST_IDLE;
                    if (rd_owner == OWN_CPU) begin
                        fetch_data  <= bus.ram_rdata;
                        fetch_valid <= 1'b1;
                    end else begin
                        dbg_data  <= bus.ram_rdata;
                        dbg_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ld_ack      = ld_ack;
    assign bus.fetch_data  = fetch_data;
    assign bus.fetch_valid = fetch_valid;
    assign bus.fetch_stall = bus.fetch_req & ~fetch_valid;
    assign bus.dbg_data    = dbg_data;
    assign bus.dbg_valid   = dbg_valid;
    assign bus.ram_en      = ram_en;
    assign bus.ram_we      = ram_we;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_wdata   = ram_wdata;

endmodule
